m2v_blkwr: RTL and testbench
============================

Name: m2v_blkwr

Overview:
- Consumer-side sequencer for the stage-3 side-information latch.
- Issues the block_start pulse that advances stage 3, then reads back the latched macroblock position and block index.
- Converts a 64-sample reconstructed 8x8 pixel stream into raster-ordered frame-memory writes for the luma, Cb and Cr planes (4:2:0).
- Sits between the reconstruction datapath and the frame-buffer write port.

Parameters:
- MBX_WIDTH, 6, macroblock column index width; luma line stride is 2^(MBX_WIDTH+4) pixels.
- MBY_WIDTH, 5, macroblock row index width.
- ADDR_WIDTH, MBX_WIDTH+MBY_WIDTH+9, frame-memory pixel address width (default 20).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- s2_avail  in  1  stage 2 holds a block ready to be latched.
- block_start  out  1  one-cycle pulse; stage 3 latches on it.
- s3_mb_x  in  MBX_WIDTH  latched macroblock column.
- s3_mb_y  in  MBY_WIDTH  latched macroblock row.
- s3_block  in  3  latched block index (0-3 luma, 4 Cb, 5 Cr).
- s3_enable  in  1  latched block valid.
- pix_data  in  8  reconstructed pixel, raster order within the block.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- wr_en  out  1  frame-memory write strobe.
- wr_addr  out  ADDR_WIDTH  write address (pixel units).
- wr_data  out  8  write data.
- blk_done  out  1  one-cycle pulse at end of each block, including skipped blocks.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and address registers 0. Reset asserted mid-block abandons the block; no further writes occur.
- FSM states:
  - IDLE: if s2_avail, go to START.
  - START: block_start=1 for exactly one cycle; go to LOAD.
  - LOAD: s3_* inputs are now valid; register the base address. If s3_enable=0 or s3_block>5, go to DONE with no writes. Otherwise go to RUN.
  - RUN: pix_ready=1. Each accept (pix_valid & pix_ready) increments a 6-bit counter {row[2:0], col[2:0]}, col fastest. The 64th accept goes to DONE.
  - DONE: blk_done=1 for one cycle; go to IDLE.
- Minimum turnaround: IDLE-START-LOAD is 2 cycles of overhead before RUN. pix_valid outside RUN is ignored; pix_ready=0 there.
- Base addresses (S = 2^(MBX_WIDTH+4), L = 2^(MBX_WIDTH+MBY_WIDTH+8)):
  - Luma, block b in 0-3: y0 = mb_y*16 + b[1]*8, x0 = mb_x*16 + b[0]*8; base = y0*S + x0.
  - Cb (b=4): base = L + (mb_y*8)*(S/2) + mb_x*8.
  - Cr (b=5): base = L + L/4 + (mb_y*8)*(S/2) + mb_x*8.
- Per-pixel address: base + row*stride + col, where stride = S for luma and S/2 for chroma.
- Write timing: registered. An accept in cycle t gives wr_en=1, wr_addr, wr_data in cycle t+1.
  - The 64th write coincides with the blk_done cycle.
  - wr_en=0 in every cycle without a preceding accept.
- pix_valid gaps stall the counter; no timeout.
- All address arithmetic is unsigned and fits in ADDR_WIDTH; no wrap occurs for legal indices.
- s2_avail high during DONE does not skip IDLE; one idle cycle always separates blocks.

Test Plan:
- Reset, then s2_avail=1 held -> block_start pulses exactly once per block, 2 cycles before the first pix_ready=1; all outputs 0 during reset.
- Luma block 3, mb_x=3, mb_y=2, 64 back-to-back pixels 0..63 -> first write addr 41016 data 0; last write addr 48191 data 63; blk_done in the same cycle as the last write.
- Cb block 4 with mb (3,2) -> first addr 532504; Cr block 5 -> first addr 663576; second row starts at +512.
- s3_enable=0, and separately s3_block=6 -> no wr_en; blk_done 2 cycles after block_start; pix_ready never asserted.
- pix_valid toggling 1,0,0,1 with random gaps -> exactly 64 writes with contiguous raster addresses; the counter holds during gaps.
- reset_n dropped after 20 pixels -> wr_en=0 immediately; FSM returns to IDLE; the next block restarts at its base address.

Source files
------------

// File: rtl/m2v_blkwr.sv
// m2v_blkwr: stage-3 block sequencer and frame-memory writer.
// Pulses block_start, reads the latched block position, then turns the
// 64 raster-ordered pixels of an 8x8 block into frame-memory writes
// across the luma, Cb and Cr planes (4:2:0).
module m2v_blkwr #(
    parameter int unsigned MBX_WIDTH  = 6,
    parameter int unsigned MBY_WIDTH  = 5,
    parameter int unsigned ADDR_WIDTH = MBX_WIDTH + MBY_WIDTH + 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s2_avail,
    output logic                  block_start,
    input  logic [MBX_WIDTH-1:0]  s3_mb_x,
    input  logic [MBY_WIDTH-1:0]  s3_mb_y,
    input  logic [2:0]            s3_block,
    input  logic                  s3_enable,
    input  logic [7:0]            pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  blk_done
);

    // Row shifts: luma stride is 2^(MBX_WIDTH+4), chroma stride is half that.
    localparam int unsigned LUMA_SHIFT   = MBX_WIDTH + 4;
    localparam int unsigned CHROMA_SHIFT = MBX_WIDTH + 3;
    localparam int unsigned PLANE_SHIFT  = MBX_WIDTH + MBY_WIDTH + 8;

    // Cb plane follows the full luma plane; Cr follows a quarter-size Cb plane.
    localparam logic [ADDR_WIDTH-1:0] CB_BASE = ADDR_WIDTH'(1) << PLANE_SHIFT;
    localparam logic [ADDR_WIDTH-1:0] CR_BASE = CB_BASE + (CB_BASE >> 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    chroma_q;
    logic [5:0]              cnt_q;

    logic [ADDR_WIDTH-1:0]   mbx_a;
    logic [ADDR_WIDTH-1:0]   mby_a;
    logic [ADDR_WIDTH-1:0]   luma_y;
    logic [ADDR_WIDTH-1:0]   luma_x;
    logic [ADDR_WIDTH-1:0]   luma_base;
    logic [ADDR_WIDTH-1:0]   chroma_base;
    logic [ADDR_WIDTH-1:0]   row_off;
    logic [ADDR_WIDTH-1:0]   pix_addr;
    logic                    skip_blk;

    // Block base address from the latched macroblock position and block index.
    assign mbx_a       = ADDR_WIDTH'(s3_mb_x);
    assign mby_a       = ADDR_WIDTH'(s3_mb_y);
    assign luma_y      = (mby_a << 4) + (ADDR_WIDTH'(s3_block[1]) << 3);
    assign luma_x      = (mbx_a << 4) + (ADDR_WIDTH'(s3_block[0]) << 3);
    assign luma_base   = (luma_y << LUMA_SHIFT) + luma_x;
    assign chroma_base = (s3_block[0] ? CR_BASE : CB_BASE)
                       + ((mby_a << 3) << CHROMA_SHIFT) + (mbx_a << 3);
    assign skip_blk    = !s3_enable || (s3_block > 3'd5);

    // Address of the pixel currently being accepted: base + row*stride + col.
    assign row_off  = chroma_q ? (ADDR_WIDTH'(cnt_q[5:3]) << CHROMA_SHIFT)
                               : (ADDR_WIDTH'(cnt_q[5:3]) << LUMA_SHIFT);
    assign pix_addr = base_q + row_off + ADDR_WIDTH'(cnt_q[2:0]);

    // Block sequencer with registered strobes and write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            chroma_q    <= 1'b0;
            cnt_q       <= '0;
            block_start <= 1'b0;
            pix_ready   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            blk_done    <= 1'b0;
        end else begin
            block_start <= 1'b0;
            blk_done    <= 1'b0;
            wr_en       <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (s2_avail) begin
                        state_q     <= ST_START;
                        block_start <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    base_q   <= s3_block[2] ? chroma_base : luma_base;
                    chroma_q <= s3_block[2];
                    cnt_q    <= '0;
                    if (skip_blk) begin
                        state_q  <= ST_DONE;
                        blk_done <= 1'b1;
                    end else begin
                        state_q   <= ST_RUN;
                        pix_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pix_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= pix_addr;
                        wr_data <= pix_data;
                        cnt_q   <= cnt_q + 6'd1;
                        if (cnt_q == 6'd63) begin
                            state_q   <= ST_DONE;
                            pix_ready <= 1'b0;
                            blk_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m2v_blkwr.sv
// Self-checking bench for m2v_blkwr: directed plane/boundary blocks plus
// randomized blocks with random pixel gaps, against an address model.
module tb_m2v_blkwr;

    localparam int unsigned MBX_WIDTH  = 6;
    localparam int unsigned MBY_WIDTH  = 5;
    localparam int unsigned ADDR_WIDTH = MBX_WIDTH + MBY_WIDTH + 9;
    localparam int unsigned S = 1 << (MBX_WIDTH + 4);
    localparam int unsigned L = 1 << (MBX_WIDTH + MBY_WIDTH + 8);

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  s2_avail = 1'b0;
    logic                  block_start;
    logic [MBX_WIDTH-1:0]  s3_mb_x = '0;
    logic [MBY_WIDTH-1:0]  s3_mb_y = '0;
    logic [2:0]            s3_block = '0;
    logic                  s3_enable = 1'b0;
    logic [7:0]            pix_data = '0;
    logic                  pix_valid = 1'b0;
    logic                  pix_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic                  blk_done;

    int errors = 0;
    int checks = 0;
    int unsigned first_addr;
    int unsigned row1_addr;
    int unsigned last_addr;
    int unsigned last_data;
    int          n_writes;

    m2v_blkwr #(
        .MBX_WIDTH (MBX_WIDTH),
        .MBY_WIDTH (MBY_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s2_avail   (s2_avail),
        .block_start(block_start),
        .s3_mb_x    (s3_mb_x),
        .s3_mb_y    (s3_mb_y),
        .s3_block   (s3_block),
        .s3_enable  (s3_enable),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .blk_done   (blk_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-memory address of pixel k (raster order) of a block.
    function automatic int unsigned ref_addr(input int mbx, input int mby, input int blk, input int k);
        int row;
        int col;
        row = k / 8;
        col = k % 8;
        if (blk < 4)
            return (mby * 16 + (blk / 2) * 8 + row) * S + mbx * 16 + (blk % 2) * 8 + col;
        else
            return L + ((blk == 5) ? L / 4 : 0) + (mby * 8 + row) * (S / 2) + mbx * 8 + col;
    endfunction

    task automatic do_reset_mid_block();
        reset_n   = 1'b0;
        pix_valid = 1'b0;
        s2_avail  = 1'b0;
        #1;
        check("abort_wr_en", 32'(wr_en), 0);
        check("abort_pix_ready", 32'(pix_ready), 0);
        check("abort_blk_done", 32'(blk_done), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one block from IDLE. Enters and leaves on a falling edge with the DUT in IDLE.
    task automatic run_block(input int mbx, input int mby, input int blk, input int en,
                             input int gap_pct, input int abort_after, input int seq_data);
        int          cyc;
        int          k;
        logic        prev_acc;
        int          prev_k;
        logic [7:0]  prev_d;
        logic [7:0]  d;
        logic        v;
        bit          finished;
        n_writes = 0;
        s2_avail = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (block_start !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("block_start_seen", 32'(block_start), 1);
        if (block_start !== 1'b1) return;
        s3_mb_x   = MBX_WIDTH'(mbx);
        s3_mb_y   = MBY_WIDTH'(mby);
        s3_block  = 3'(blk);
        s3_enable = en[0];
        @(negedge clk);
        check("load_block_start", 32'(block_start), 0);
        check("load_pix_ready", 32'(pix_ready), 0);
        check("load_wr_en", 32'(wr_en), 0);
        @(negedge clk);
        if (en == 0 || blk > 5) begin
            check("skip_blk_done", 32'(blk_done), 1);
            check("skip_pix_ready", 32'(pix_ready), 0);
            check("skip_wr_en", 32'(wr_en), 0);
            pix_valid = 1'b1;
            @(negedge clk);
            pix_valid = 1'b0;
            check("skip_idle_done", 32'(blk_done), 0);
            check("skip_idle_wr_en", 32'(wr_en), 0);
            check("skip_idle_ready", 32'(pix_ready), 0);
            return;
        end
        check("run_pix_ready", 32'(pix_ready), 1);
        k = 0;
        prev_acc = 1'b0;
        prev_k = 0;
        prev_d = '0;
        cyc = 0;
        finished = 1'b0;
        while (cyc < 3000 && !finished) begin
            check("wr_en", 32'(wr_en), 32'(prev_acc));
            if (prev_acc && wr_en) begin
                n_writes++;
                check("wr_addr", 32'(wr_addr), ref_addr(mbx, mby, blk, prev_k));
                check("wr_data", 32'(wr_data), 32'(prev_d));
                if (prev_k == 0) first_addr = 32'(wr_addr);
                if (prev_k == 8) row1_addr = 32'(wr_addr);
                if (prev_k == 63) begin
                    last_addr = 32'(wr_addr);
                    last_data = 32'(wr_data);
                end
            end
            if (k == 64) begin
                check("last_blk_done", 32'(blk_done), 1);
                check("last_pix_ready", 32'(pix_ready), 0);
                check("last_block_start", 32'(block_start), 0);
                finished = 1'b1;
            end else begin
                check("run_blk_done", 32'(blk_done), 0);
                check("run_ready", 32'(pix_ready), 1);
                if (abort_after > 0 && k == abort_after) begin
                    do_reset_mid_block();
                    return;
                end
                v = ($urandom_range(0, 99) >= 32'(gap_pct));
                d = seq_data != 0 ? 8'(k) : 8'($urandom);
                pix_valid = v;
                pix_data  = d;
                prev_acc  = v;
                if (v) begin
                    prev_k = k;
                    prev_d = d;
                    k++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) check("run_timeout", 0, 1);
        pix_valid = 1'b0;
        check("write_count", 32'(n_writes), finished ? 64 : 32'(n_writes) + 1);
        @(negedge clk);
        check("idle_blk_done", 32'(blk_done), 0);
        check("idle_wr_en", 32'(wr_en), 0);
        check("idle_block_start", 32'(block_start), 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        s2_avail = 1'b1;
        pix_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs", {block_start, pix_ready, wr_en, blk_done}, 0);
            check("rst_wr_addr", 32'(wr_addr), 0);
            check("rst_wr_data", 32'(wr_data), 0);
        end
        pix_valid = 1'b0;
        reset_n = 1'b1;

        // Luma block 3 at (3,2), back-to-back sequential pixels.
        run_block(3, 2, 3, 1, 0, 0, 1);
        check("luma_first_addr", first_addr, 41016);
        check("luma_last_addr", last_addr, 48191);
        check("luma_last_data", last_data, 63);

        // Chroma planes at (3,2), with a one-row stride check.
        run_block(3, 2, 4, 1, 0, 0, 0);
        check("cb_first_addr", first_addr, 532504);
        check("cb_row1_addr", row1_addr, 532504 + 512);
        run_block(3, 2, 5, 1, 20, 0, 0);
        check("cr_first_addr", first_addr, 663576);
        check("cr_row1_addr", row1_addr, 663576 + 512);

        // Skipped blocks: disabled, and out-of-range indices.
        run_block(3, 2, 0, 0, 0, 0, 0);
        run_block(3, 2, 6, 1, 0, 0, 0);
        run_block(5, 7, 7, 1, 0, 0, 0);

        // Heavy random gaps.
        run_block(10, 4, 1, 1, 60, 0, 1);

        // Abort after 20 pixels, then a clean restart of the same block.
        run_block(3, 2, 3, 1, 25, 20, 1);
        run_block(3, 2, 3, 1, 25, 0, 1);
        check("restart_first_addr", first_addr, 41016);

        // Randomized blocks, including extreme macroblock positions.
        run_block(63, 31, 3, 1, 30, 0, 0);
        run_block(63, 31, 5, 1, 30, 0, 0);
        run_block(0, 0, 0, 1, 30, 0, 0);
        for (int i = 0; i < 12; i++) begin
            run_block(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 9) != 0),
                      int'($urandom_range(0, 50)), 0, 0);
        end

        s2_avail = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
